queue_calc_sequencer: RTL

Front-end controller and sole driver of the 5-entry calculator operand queue. It takes a stream of operand and operator tokens over a valid/ready handshake and issues the matching queue commands (`opcode`, `back`, plus a write strobe). It evaluates each operator against the queue's two front entries (`top_conc`) and returns the final result over a second valid/ready handshake. It sits between the token source and the queue, and also holds the arithmetic unit.

---
 rtl/queue_calc_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/queue_calc_sequencer.sv
// Token front-end for the 5-entry calculator queue: turns operand/operator tokens into
// queue commands, evaluates operators on the queue's front pair and returns the result.
module queue_calc_sequencer #(
   parameter int DEPTH = 5,
   parameter int W     = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tok_valid,
   output logic           tok_ready,
   input  logic           tok_is_op,
   input  logic [W-1:0]   tok_data,
   input  logic           tok_last,
   output logic [1:0]     q_opcode,
   output logic [W-1:0]   q_back,
   output logic           q_we,
   input  logic [2*W-1:0] top_conc,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [W-1:0]   res_data,
   output logic [2:0]     count,
   output logic           err,
   output logic [2:0]     err_code
);
   typedef enum logic [2:0] {IDLE, PUSH, EXEC, WRITE, RESULT, ERROR} state_t;

   localparam logic [2:0] ERR_OVF  = 3'b001;
   localparam logic [2:0] ERR_UNF  = 3'b010;
   localparam logic [2:0] ERR_DIV0 = 3'b011;
   localparam logic [2:0] ERR_LEFT = 3'b100;

   state_t       state_reg, state_next;
   logic [2:0]   count_reg, count_next, new_count;
   logic [2:0]   err_code_reg, err_code_next;
   logic [W-1:0] data_reg, data_next;
   logic [W-1:0] result_reg, result_next;
   logic         last_reg, last_next;
   logic [W-1:0] op_a, op_b;

   assign op_a     = top_conc[2*W-1:W];
   assign op_b     = top_conc[W-1:0];
   assign count    = count_reg;
   assign err      = (state_reg == ERROR);
   assign err_code = err_code_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         err_code_reg <= '0;
         data_reg     <= '0;
         result_reg   <= '0;
         last_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         err_code_reg <= err_code_next;
         data_reg     <= data_next;
         result_reg   <= result_next;
         last_reg     <= last_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      new_count     = count_reg;
      err_code_next = err_code_reg;
      data_next     = data_reg;
      result_next   = result_reg;
      last_next     = last_reg;
      tok_ready     = 1'b0;
      q_we          = 1'b0;
      q_opcode      = 2'b00;
      q_back        = data_reg;
      res_valid     = 1'b0;
      res_data      = op_a;

      case (state_reg)
         IDLE: begin
            tok_ready = 1'b1;
            if (tok_valid) begin
               data_next = tok_data;
               last_next = tok_last;
               if (!tok_is_op) begin
                  if (count_reg == 3'(DEPTH)) begin
                     state_next    = ERROR;
                     err_code_next = ERR_OVF;
                  end else begin
                     state_next = PUSH;
                  end
               end else if (count_reg < 3'd2) begin
                  state_next    = ERROR;
                  err_code_next = ERR_UNF;
               end else begin
                  state_next = EXEC;
               end
            end
         end
         PUSH: begin
            q_we      = 1'b1;
            q_opcode  = 2'b00;
            q_back    = data_reg;
            new_count = count_reg + 3'd1;
         end
         EXEC: begin
            state_next = WRITE;
            case (data_reg[1:0])
               2'b00: result_next = op_a + op_b;
               2'b01: result_next = op_a - op_b;
               2'b10: result_next = op_a * op_b;
               default: begin
                  if (op_b == '0) begin
                     state_next    = ERROR;
                     err_code_next = ERR_DIV0;
                  end else begin
                     result_next = op_a / op_b;
                  end
               end
            endcase
         end
         WRITE: begin
            q_we      = 1'b1;
            q_opcode  = 2'b10;
            q_back    = result_reg;
            new_count = count_reg - 3'd1;
         end
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               q_we       = 1'b1;
               q_opcode   = 2'b11;
               count_next = '0;
               state_next = IDLE;
            end
         end
         default: ;
      endcase

      // Once the queue command commits, the last token decides whether a single result remains.
      if (state_reg == PUSH || state_reg == WRITE) begin
         count_next = new_count;
         if (!last_reg) begin
            state_next = IDLE;
         end else if (new_count == 3'd1) begin
            state_next = RESULT;
         end else begin
            state_next    = ERROR;
            err_code_next = (new_count == 3'd0) ? ERR_UNF : ERR_LEFT;
         end
      end
   end
endmodule
